reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural register file with per-register rename tags.
- Sits directly downstream of the reorder buffer. Consumes its commit stream (set_id/set_val/set_from_rob_id) and its issue-time dependency stream (set_dep_id/set_dep_Q).
- Answers the decoder's two source-operand lookups. A lookup returns either a ready value or the ROB tag to wait on.
- Resolves operands already produced but not committed by forwarding a lookup to the ROB's availability ports.

Parameters:
- ROB_W, 4, ROB index width; ROB depth is 2**ROB_W.
- XLEN, 32, register data width.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  asynchronous active-high reset.
- rdy_in  input  1  global enable; low = hold all state.
- rob_clear  input  1  mispredict flush from ROB.
- set_id  input  5  commit destination register; 0 = no commit.
- set_val  input  XLEN  commit value.
- set_from_rob_id  input  ROB_W  ROB entry being committed.
- set_dep_id  input  5  register renamed by the issuing instruction; 0 = none.
- set_dep_Q  input  ROB_W  ROB entry that will produce set_dep_id.
- get_id_1  input  5  decoder source register 1.
- get_id_2  input  5  decoder source register 2.
- get_rob_id_1  output  ROB_W  tag forwarded to ROB for source 1.
- rob_avail_1  input  1  ROB: entry get_rob_id_1 has its result.
- rob_val_1  input  XLEN  ROB: that result.
- get_rob_id_2  output  ROB_W  tag forwarded to ROB for source 2.
- rob_avail_2  input  1  ROB: entry get_rob_id_2 has its result.
- rob_val_2  input  XLEN  ROB: that result.
- val_1  output  XLEN  source 1 value; valid when has_dep_1 = 0.
- has_dep_1  output  1  source 1 still pending.
- dep_1  output  ROB_W  ROB tag source 1 waits on.
- val_2  output  XLEN  source 2 value; valid when has_dep_2 = 0.
- has_dep_2  output  1  source 2 still pending.
- dep_2  output  ROB_W  ROB tag source 2 waits on.

Behaviour:
- State: 32 entries, each holding {val[XLEN], busy, tag[ROB_W]}. Entry 0 is hardwired: val 0, busy 0, and ignores every write.
- Reset (async, rst_in = 1): every val, busy and tag goes to 0 immediately, regardless of rdy_in. Outputs follow combinationally.
- rdy_in = 0 and no reset: no state change. Read outputs remain combinational.
- rob_clear = 1 with rdy_in = 1: all busy bits go to 0 and all tags to 0. val is unchanged.
  - The commit and dep inputs are ignored in this cycle. The ROB is flushing and its head is not committed.
- Commit (rdy_in = 1, rob_clear = 0, set_id != 0):
  - val[set_id] <= set_val, unconditionally.
  - busy[set_id] <= 0 only if tag[set_id] == set_from_rob_id, i.e. no younger rename exists.
- Dependency (rdy_in = 1, rob_clear = 0, set_dep_id != 0):
  - busy[set_dep_id] <= 1 and tag[set_dep_id] <= set_dep_Q.
  - When commit and dep target the same register in the same cycle, the dep wins: busy stays 1 and tag takes the new value, while val still takes set_val.
- Read path (per source k, fully combinational, zero latency):
  - get_rob_id_k = tag[get_id_k].
  - If get_id_k == 0: val_k = 0, has_dep_k = 0.
  - Else if !busy: val_k = stored val, has_dep_k = 0.
  - Else if set_id == get_id_k (set_id != 0) and set_from_rob_id == tag: commit bypass; val_k = set_val, has_dep_k = 0.
  - Else if rob_avail_k: val_k = rob_val_k, has_dep_k = 0.
  - Else: has_dep_k = 1, dep_k = tag. val_k is don't-care; drive the stored val.
  - dep_k always equals tag[get_id_k] and is meaningful only when has_dep_k = 1.
  - Reads reflect state before the clock edge. A dep written in the same cycle by the same instruction is not visible to its own lookup, which is correct for rd == rs.
  - When rob_clear = 1, read outputs are don't-care; the decoder does not issue in that cycle.
- No backpressure and no handshake: every valid input is consumed in the cycle it is presented.

Test Plan:
- Reset then read x5: val_1 = 0, has_dep_1 = 0. Assert rst_in mid-cycle after writing x5 = 0x1234: the read returns 0 before the next edge.
- Dep x3 <- tag 7, next cycle read x3 with rob_avail_1 = 0: has_dep_1 = 1, dep_1 = 7, get_rob_id_1 = 7. Raise rob_avail_1 with rob_val_1 = 0xAA: val_1 = 0xAA, has_dep_1 = 0.
- Commit x3 = 0x55 from tag 7 while reading x3: val_1 = 0x55 with no dep in the same cycle (bypass). Next cycle busy = 0 and val = 0x55.
- Dep x4 <- tag 2, then dep x4 <- tag 9, then commit x4 = 0x10 from tag 2: val = 0x10, busy stays 1, tag = 9. Same-cycle commit(x6, tag 1) with dep(x6, tag 3) after dep x6 <- tag 1: busy = 1, tag = 3.
- Writes to x0 (commit 0xFFFF, dep tag 5): reads of x0 give val 0, has_dep 0.
- With x1, x2 busy, pulse rob_clear together with a commit of x1 = 0x77: busy bits clear and x1 keeps its old value. Hold rdy_in = 0 with commit and dep active: no state change.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Commit and dependency streams come from the ROB; two combinational source
// lookups serve the decoder, forwarding through the ROB when a value has been
// produced but not yet committed.

// Single source-operand lookup: resolves one register read into either a ready
// value or the ROB tag to wait on.
module reg_file_rd_port #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic [4:0]       get_id,
    input  logic [XLEN-1:0]  ent_val,
    input  logic             ent_busy,
    input  logic [ROB_W-1:0] ent_tag,
    input  logic [4:0]       set_id,
    input  logic [XLEN-1:0]  set_val,
    input  logic [ROB_W-1:0] set_from_rob_id,
    input  logic             rob_avail,
    input  logic [XLEN-1:0]  rob_val,
    output logic [ROB_W-1:0] get_rob_id,
    output logic [XLEN-1:0]  val,
    output logic             has_dep,
    output logic [ROB_W-1:0] dep
);
    assign get_rob_id = ent_tag;
    assign dep        = ent_tag;

    // Priority: x0, idle register, same-cycle commit bypass, ROB forward, wait.
    always_comb begin
        val     = ent_val;
        has_dep = 1'b0;
        if (get_id == 5'd0) begin
            val = '0;
        end else if (!ent_busy) begin
            val = ent_val;
        end else if (set_id == get_id && set_from_rob_id == ent_tag) begin
            val = set_val;
        end else if (rob_avail) begin
            val = rob_val;
        end else begin
            has_dep = 1'b1;
        end
    end
endmodule

module reg_file #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic [4:0]       set_id,
    input  logic [XLEN-1:0]  set_val,
    input  logic [ROB_W-1:0] set_from_rob_id,
    input  logic [4:0]       set_dep_id,
    input  logic [ROB_W-1:0] set_dep_Q,
    input  logic [4:0]       get_id_1,
    input  logic [4:0]       get_id_2,
    output logic [ROB_W-1:0] get_rob_id_1,
    input  logic             rob_avail_1,
    input  logic [XLEN-1:0]  rob_val_1,
    output logic [ROB_W-1:0] get_rob_id_2,
    input  logic             rob_avail_2,
    input  logic [XLEN-1:0]  rob_val_2,
    output logic [XLEN-1:0]  val_1,
    output logic             has_dep_1,
    output logic [ROB_W-1:0] dep_1,
    output logic [XLEN-1:0]  val_2,
    output logic             has_dep_2,
    output logic [ROB_W-1:0] dep_2
);
    localparam int NUM_SRC = 2;

    logic [31:0][XLEN-1:0]  val_q;
    logic [31:0]            busy_q;
    logic [31:0][ROB_W-1:0] tag_q;

    logic commit_en;
    logic dep_en;

    assign commit_en = (set_id != 5'd0);
    assign dep_en    = (set_dep_id != 5'd0);

    // State update. Entry 0 is never addressed by a write, so it stays zero.
    // The dep assignment comes after the commit so a same-register collision
    // leaves the register renamed to the newer tag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                busy_q <= '0;
                tag_q  <= '0;
            end else begin
                if (commit_en) begin
                    val_q[set_id] <= set_val;
                    if (tag_q[set_id] == set_from_rob_id)
                        busy_q[set_id] <= 1'b0;
                end
                if (dep_en) begin
                    busy_q[set_dep_id] <= 1'b1;
                    tag_q[set_dep_id]  <= set_dep_Q;
                end
            end
        end
    end

    logic [NUM_SRC-1:0][4:0]       src_id;
    logic [NUM_SRC-1:0]            src_avail;
    logic [NUM_SRC-1:0][XLEN-1:0]  src_rob_val;
    logic [NUM_SRC-1:0][ROB_W-1:0] src_rob_id;
    logic [NUM_SRC-1:0][XLEN-1:0]  src_val;
    logic [NUM_SRC-1:0]            src_has_dep;
    logic [NUM_SRC-1:0][ROB_W-1:0] src_dep;

    assign src_id      = {get_id_2, get_id_1};
    assign src_avail   = {rob_avail_2, rob_avail_1};
    assign src_rob_val = {rob_val_2, rob_val_1};

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        reg_file_rd_port #(.ROB_W(ROB_W), .XLEN(XLEN)) u_port (
            .get_id          (src_id[k]),
            .ent_val         (val_q[src_id[k]]),
            .ent_busy        (busy_q[src_id[k]]),
            .ent_tag         (tag_q[src_id[k]]),
            .set_id          (set_id),
            .set_val         (set_val),
            .set_from_rob_id (set_from_rob_id),
            .rob_avail       (src_avail[k]),
            .rob_val         (src_rob_val[k]),
            .get_rob_id      (src_rob_id[k]),
            .val             (src_val[k]),
            .has_dep         (src_has_dep[k]),
            .dep             (src_dep[k])
        );
    end

    assign get_rob_id_1 = src_rob_id[0];
    assign get_rob_id_2 = src_rob_id[1];
    assign val_1        = src_val[0];
    assign val_2        = src_val[1];
    assign has_dep_1    = src_has_dep[0];
    assign has_dep_2    = src_has_dep[1];
    assign dep_1        = src_dep[0];
    assign dep_2        = src_dep[1];
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios then random traffic, with a
// register-level reference model feeding an expectation queue that a
// negedge monitor drains and compares.
module tb_reg_file;
    localparam int ROB_W = 4;
    localparam int XLEN  = 32;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, rob_clear;
    logic [4:0]       set_id, set_dep_id, get_id_1, get_id_2;
    logic [XLEN-1:0]  set_val, rob_val_1, rob_val_2, val_1, val_2;
    logic [ROB_W-1:0] set_from_rob_id, set_dep_Q, get_rob_id_1, get_rob_id_2, dep_1, dep_2;
    logic             rob_avail_1, rob_avail_2, has_dep_1, has_dep_2;

    reg_file #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .set_id(set_id), .set_val(set_val), .set_from_rob_id(set_from_rob_id),
        .set_dep_id(set_dep_id), .set_dep_Q(set_dep_Q),
        .get_id_1(get_id_1), .get_id_2(get_id_2),
        .get_rob_id_1(get_rob_id_1), .rob_avail_1(rob_avail_1), .rob_val_1(rob_val_1),
        .get_rob_id_2(get_rob_id_2), .rob_avail_2(rob_avail_2), .rob_val_2(rob_val_2),
        .val_1(val_1), .has_dep_1(has_dep_1), .dep_1(dep_1),
        .val_2(val_2), .has_dep_2(has_dep_2), .dep_2(dep_2)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic             rst, rdy, clr;
        logic [4:0]       sid;
        logic [XLEN-1:0]  sval;
        logic [ROB_W-1:0] sfrom;
        logic [4:0]       did;
        logic [ROB_W-1:0] dq;
        logic [4:0]       g [2];
        logic             av [2];
        logic [XLEN-1:0]  rv [2];
    } stim_t;

    typedef struct {
        logic             chk;
        logic [ROB_W-1:0] rid [2];
        logic             hd [2];
        logic [ROB_W-1:0] dep [2];
        logic [XLEN-1:0]  val [2];
    } exp_t;

    // Reference state: what each architectural register holds.
    logic [XLEN-1:0]  m_val  [32];
    logic             m_busy [32];
    logic [ROB_W-1:0] m_tag  [32];

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.rdy = 1; s.clr = 0;
        s.sid = 0; s.sval = 0; s.sfrom = 0; s.did = 0; s.dq = 0;
        for (int k = 0; k < 2; k++) begin
            s.g[k] = 0; s.av[k] = 0; s.rv[k] = 0;
        end
        return s;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            m_val[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
        end
    endfunction

    // Expected lookup result from the register's current state.
    function automatic exp_t predict(stim_t s);
        exp_t e;
        e.chk = !s.clr;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] r;
            r = s.g[k];
            e.rid[k] = m_tag[r];
            e.dep[k] = m_tag[r];
            e.hd[k]  = 1'b0;
            e.val[k] = m_val[r];
            if (r == 0)                                      e.val[k] = 0;
            else if (!m_busy[r])                             e.val[k] = m_val[r];
            else if (s.sid == r && s.sfrom == m_tag[r])      e.val[k] = s.sval;
            else if (s.av[k])                                e.val[k] = s.rv[k];
            else                                             e.hd[k]  = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_step(stim_t s);
        if (s.rst || !s.rdy) return;
        if (s.clr) begin
            for (int r = 0; r < 32; r++) begin
                m_busy[r] = 0; m_tag[r] = 0;
            end
            return;
        end
        if (s.sid != 0) begin
            m_val[s.sid] = s.sval;
            if (m_tag[s.sid] == s.sfrom) m_busy[s.sid] = 0;
        end
        if (s.did != 0) begin
            m_busy[s.did] = 1;
            m_tag[s.did]  = s.dq;
        end
    endfunction

    // Called at posedge+1: apply inputs, queue expectation, advance one edge.
    task automatic cyc(input stim_t s);
        rst_in = s.rst; rdy_in = s.rdy; rob_clear = s.clr;
        set_id = s.sid; set_val = s.sval; set_from_rob_id = s.sfrom;
        set_dep_id = s.did; set_dep_Q = s.dq;
        get_id_1 = s.g[0]; get_id_2 = s.g[1];
        rob_avail_1 = s.av[0]; rob_avail_2 = s.av[1];
        rob_val_1 = s.rv[0]; rob_val_2 = s.rv[1];
        if (s.rst) model_clear();
        exp_q.push_back(predict(s));
        @(posedge clk_in);
        #1;
        model_step(s);
    endtask

    task automatic chk(input string nm, input int k, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got %h want %h", nm, k + 1, $time, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so one sample per cycle mid-period.
    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [XLEN-1:0]  a_val [2];
            logic             a_hd  [2];
            logic [ROB_W-1:0] a_dep [2];
            logic [ROB_W-1:0] a_rid [2];
            e = exp_q.pop_front();
            a_val = '{val_1, val_2};
            a_hd  = '{has_dep_1, has_dep_2};
            a_dep = '{dep_1, dep_2};
            a_rid = '{get_rob_id_1, get_rob_id_2};
            if (e.chk) begin
                for (int k = 0; k < 2; k++) begin
                    chk("get_rob_id", k, XLEN'(a_rid[k]), XLEN'(e.rid[k]));
                    chk("has_dep", k, XLEN'(a_hd[k]), XLEN'(e.hd[k]));
                    if (e.hd[k]) chk("dep", k, XLEN'(a_dep[k]), XLEN'(e.dep[k]));
                    else         chk("val", k, a_val[k], e.val[k]);
                end
            end
        end
    end

    initial begin
        stim_t s;
        model_clear();
        s = idle();
        s.rst = 1;
        rst_in = 1; rdy_in = 0; rob_clear = 0; set_id = 0; set_val = 0;
        set_from_rob_id = 0; set_dep_id = 0; set_dep_Q = 0; get_id_1 = 0; get_id_2 = 0;
        rob_avail_1 = 0; rob_avail_2 = 0; rob_val_1 = 0; rob_val_2 = 0;
        @(posedge clk_in); #1;

        // Reset state, then write x5 and assert reset mid-cycle while reading it.
        s = idle(); s.rst = 1; s.g[0] = 5; cyc(s);
        s = idle(); s.sid = 5; s.sval = 32'h1234; cyc(s);
        s = idle(); s.g[0] = 5; s.g[1] = 5; cyc(s);
        s = idle(); s.rst = 1; s.g[0] = 5; cyc(s);

        // Dependency, ROB forward, commit bypass.
        s = idle(); s.did = 3; s.dq = 7; cyc(s);
        s = idle(); s.g[0] = 3; s.g[1] = 3; cyc(s);
        s = idle(); s.g[0] = 3; s.av[0] = 1; s.rv[0] = 32'hAA; s.g[1] = 3; cyc(s);
        s = idle(); s.sid = 3; s.sval = 32'h55; s.sfrom = 7; s.g[0] = 3; cyc(s);
        s = idle(); s.g[0] = 3; s.g[1] = 3; cyc(s);

        // Stale commit against a younger rename; commit and dep colliding.
        s = idle(); s.did = 4; s.dq = 2; cyc(s);
        s = idle(); s.did = 4; s.dq = 9; cyc(s);
        s = idle(); s.sid = 4; s.sval = 32'h10; s.sfrom = 2; s.g[0] = 4; cyc(s);
        s = idle(); s.g[0] = 4; s.g[1] = 4; s.av[1] = 1; s.rv[1] = 32'h99; cyc(s);
        s = idle(); s.did = 6; s.dq = 1; cyc(s);
        s = idle(); s.sid = 6; s.sval = 32'h66; s.sfrom = 1; s.did = 6; s.dq = 3; cyc(s);
        s = idle(); s.g[0] = 6; s.g[1] = 6; s.av[1] = 1; s.rv[1] = 32'h5A; cyc(s);

        // x0 is immune to writes.
        s = idle(); s.sid = 0; s.sval = 32'hFFFF; s.did = 0; s.dq = 5; s.g[0] = 0; cyc(s);
        s = idle(); s.g[0] = 0; s.g[1] = 0; cyc(s);

        // Flush with a commit in flight, then rdy_in low holding state.
        s = idle(); s.sid = 1; s.sval = 32'h11; cyc(s);
        s = idle(); s.did = 1; s.dq = 4; cyc(s);
        s = idle(); s.did = 2; s.dq = 5; cyc(s);
        s = idle(); s.clr = 1; s.sid = 1; s.sval = 32'h77; s.sfrom = 4; cyc(s);
        s = idle(); s.g[0] = 1; s.g[1] = 2; cyc(s);
        s = idle(); s.rdy = 0; s.sid = 1; s.sval = 32'hDEAD; s.did = 2; s.dq = 8; cyc(s);
        s = idle(); s.g[0] = 1; s.g[1] = 2; cyc(s);

        // Random traffic over a small register window to force collisions.
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst   = ($urandom_range(0, 199) == 0);
            s.rdy   = ($urandom_range(0, 9) != 0);
            s.clr   = ($urandom_range(0, 29) == 0);
            s.sid   = 5'($urandom_range(0, 7));
            s.sval  = $urandom;
            s.sfrom = ($urandom_range(0, 1) == 0) ? m_tag[s.sid] : ROB_W'($urandom);
            s.did   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
            s.dq    = ROB_W'($urandom);
            for (int k = 0; k < 2; k++) begin
                s.g[k]  = 5'($urandom_range(0, 7));
                s.av[k] = ($urandom_range(0, 3) == 0);
                s.rv[k] = $urandom;
            end
            cyc(s);
        end

        s = idle();
        cyc(s);
        @(posedge clk_in); #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
